if_id_skid_reg: RTL and testbench
=================================

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 The block SHALL have parameter OPC_W, default 3, opcode field width.
REQ-002 The block SHALL have parameter AD_W, default 5, register-address field width.
REQ-003 The block SHALL have parameter IMM_W, default 8, immediate field width.
REQ-004 The block SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-005 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port flush  in  1  discards all held entries (branch/redirect).
REQ-008 The block SHALL have port stall  in  1  hazard hold from the ID side.
REQ-009 The block SHALL have port in_valid  in  1  IF beat valid.
REQ-010 The block SHALL have port in_ready  out  1  block can accept a beat; driven from a register.
REQ-011 The block SHALL have ports in_opcode/in_ad1/in_imm  in  OPC_W/AD_W/IMM_W  IF payload.
REQ-012 The block SHALL have port out_valid  out  1  ID beat valid.
REQ-013 The block SHALL have port out_ready  in  1  ID accepts beat.
REQ-014 The block SHALL have ports out_opcode/out_ad1/out_imm  out  OPC_W/AD_W/IMM_W  ID payload.
REQ-015 The block SHALL have port occupancy  out  2  held entries, 0..2.
REQ-016 The block SHALL have port bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Function
REQ-017 Storage SHALL be one output register (OUT) plus one skid register (SKID); states EMPTY(0), ONE(1), TWO(2) = occupancy.
REQ-018 accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 out_valid SHALL equal (occupancy != 0) & !stall; payload outputs are driven from OUT regardless of stall.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, updated registered with the state.
REQ-021 EMPTY: accept -> ONE, payload into OUT; else stay.
REQ-022 ONE: accept & pop -> ONE, new payload into OUT; accept & !pop -> TWO, payload into SKID; pop & !accept -> EMPTY; neither -> hold.
REQ-023 TWO: pop -> ONE, SKID copied to OUT; else hold; no accept possible.
REQ-024 Ordering SHALL be strict FIFO; no beat is duplicated or lost except by flush.
REQ-025 flush SHALL take priority: next state EMPTY, in_ready=1, OUT/SKID payload unchanged; a beat accepted in the flush cycle is dropped.
REQ-026 stall SHALL suppress pop (out_valid=0) but SHALL NOT block accept while in_ready=1.
REQ-027 Input-to-output latency SHALL be 1 cycle from accept into EMPTY (or ONE with pop); throughput 1 beat/cycle with out_ready=1 and stall=0.
REQ-028 bubble_cnt SHALL increment by 1 each cycle out_valid=0 and rst=0, saturating at 2^CNT_W-1; it is not cleared by flush.

Reset
REQ-029 rst=1 at a rising edge SHALL force occupancy=0, in_ready=1, out_valid=0, OUT and SKID payloads=0, bubble_cnt=0, overriding flush/accept/pop.
REQ-030 While rst=1, in_ready SHALL read 1 after the first edge and no accept SHALL be recorded; reset mid-TWO discards both entries.

Verification
REQ-031 Reset then stream opcodes 1,2,3 with out_ready=1 -> out_opcode 1,2,3 on consecutive cycles, each one cycle after its input; occupancy stays 1.
REQ-032 Fill with A,B while out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> A then B emitted, in_ready=1 again after first pop.
REQ-033 occupancy=2, assert flush with in_valid=1 (payload C) -> next cycle occupancy=0, out_valid=0, C never appears at output.
REQ-034 occupancy=1 (payload D), stall=1 for 3 cycles, out_ready=1 -> out_valid=0 for 3 cycles, bubble_cnt +3, D emitted on first cycle after stall drops.
REQ-035 CNT_W=4, idle 20 cycles after reset -> bubble_cnt saturates at 15 and holds.
REQ-036 occupancy=2 then rst=1 for one cycle -> occupancy=0, all payload outputs 0, in_ready=1, bubble_cnt=0.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with one skid slot: registered in_ready, strict FIFO order,
// flush discards held beats, stall gates out_valid, and a saturating bubble counter.
module if_id_skid_reg #(
  parameter int OPC_W = 3,
  parameter int AD_W  = 5,
  parameter int IMM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [AD_W-1:0]  in_ad1,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] out_opcode,
  output logic [AD_W-1:0]  out_ad1,
  output logic [IMM_W-1:0] out_imm,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [OPC_W-1:0]   out_opc_q, out_opc_d, skid_opc_q, skid_opc_d;
  logic [AD_W-1:0]    out_ad_q, out_ad_d, skid_ad_q, skid_ad_d;
  logic [IMM_W-1:0]   out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [CNT_W-1:0]   bubble_q, bubble_d;
  logic               accept_s;
  logic               pop_s;
  logic               out_valid_s;

  assign out_valid_s = (state_q != EMPTY) && !stall;
  assign accept_s    = in_valid && in_ready_q;
  assign pop_s       = out_valid_s && out_ready;

  // Next-state, payload steering and bubble counting
  always_comb begin
    state_d    = state_q;
    out_opc_d  = out_opc_q;
    out_ad_d   = out_ad_q;
    out_imm_d  = out_imm_q;
    skid_opc_d = skid_opc_q;
    skid_ad_d  = skid_ad_q;
    skid_imm_d = skid_imm_q;
    bubble_d   = bubble_q;

    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          state_d   = ONE;
          out_opc_d = in_opcode;
          out_ad_d  = in_ad1;
          out_imm_d = in_imm;
        end else begin
          state_d = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          out_opc_d = in_opcode;
          out_ad_d  = in_ad1;
          out_imm_d = in_imm;
        end else if (accept_s) begin
          state_d    = TWO;
          skid_opc_d = in_opcode;
          skid_ad_d  = in_ad1;
          skid_imm_d = in_imm;
        end else if (pop_s) begin
          state_d = EMPTY;
        end else begin
          state_d = ONE;
        end
      end
      TWO: begin
        if (pop_s) begin
          state_d   = ONE;
          out_opc_d = skid_opc_q;
          out_ad_d  = skid_ad_q;
          out_imm_d = skid_imm_q;
        end else begin
          state_d = TWO;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush only empties the queue; stored payload bits are left as they were.
    if (flush) begin
      state_d    = EMPTY;
      out_opc_d  = out_opc_q;
      out_ad_d   = out_ad_q;
      out_imm_d  = out_imm_q;
      skid_opc_d = skid_opc_q;
      skid_ad_d  = skid_ad_q;
      skid_imm_d = skid_imm_q;
    end else begin
      state_d = state_d;
    end

    in_ready_d = (state_d != TWO);

    if (!out_valid_s && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end else begin
      bubble_d = bubble_q;
    end
  end

  // State, payload and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      out_opc_q  <= '0;
      out_ad_q   <= '0;
      out_imm_q  <= '0;
      skid_opc_q <= '0;
      skid_ad_q  <= '0;
      skid_imm_q <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_opc_q  <= out_opc_d;
      out_ad_q   <= out_ad_d;
      out_imm_q  <= out_imm_d;
      skid_opc_q <= skid_opc_d;
      skid_ad_q  <= skid_ad_d;
      skid_imm_q <= skid_imm_d;
      bubble_q   <= bubble_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_s;
  assign out_opcode = out_opc_q;
  assign out_ad1    = out_ad_q;
  assign out_imm    = out_imm_q;
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed table-driven bench for if_id_skid_reg plus hand sequences for stall,
// bubble saturation (CNT_W=4 instance) and reset while full.
module tb_if_id_skid_reg;

  logic        clk;
  logic        rst, flush, stall, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [3:0]  in_opcode, out_opcode;
  logic [4:0]  in_ad1, out_ad1;
  logic [7:0]  in_imm, out_imm;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic        rst2;
  logic        in_ready2, out_valid2;
  logic [2:0]  out_opcode2;
  logic [4:0]  out_ad12;
  logic [7:0]  out_imm2;
  logic [1:0]  occupancy2;
  logic [3:0]  bubble_cnt2;

  int total = 0;
  int bad   = 0;

  if_id_skid_reg #(.OPC_W(4), .AD_W(5), .IMM_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_ad1(in_ad1), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_ad1(out_ad1), .out_imm(out_imm),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  if_id_skid_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .flush(1'b0), .stall(1'b0),
    .in_valid(1'b0), .in_ready(in_ready2),
    .in_opcode(3'd0), .in_ad1(5'd0), .in_imm(8'd0),
    .out_valid(out_valid2), .out_ready(1'b1),
    .out_opcode(out_opcode2), .out_ad1(out_ad12), .out_imm(out_imm2),
    .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl, st, iv, ordy;
    logic [3:0] op;
    logic [1:0] e_occ;
    logic       e_ir, e_ov;
    logic [3:0] e_op;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(input logic fl, st, iv, ordy, input logic [3:0] op,
                              input logic [1:0] e_occ, input logic e_ir, e_ov,
                              input logic [3:0] e_op);
    vec_t v;
    v.fl = fl; v.st = st; v.iv = iv; v.ordy = ordy; v.op = op;
    v.e_occ = e_occ; v.e_ir = e_ir; v.e_ov = e_ov; v.e_op = e_op;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, st, iv, ordy, input logic [3:0] op);
    flush = fl; stall = st; in_valid = iv; out_ready = ordy;
    in_opcode = op; in_ad1 = {1'b1, op}; in_imm = {op, op};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fl st iv ordy op | occ ir ov op
    vt[0]  = mk(0,0,1,1,4'd1,  2'd1,1,1,4'd1);
    vt[1]  = mk(0,0,1,1,4'd2,  2'd1,1,1,4'd2);
    vt[2]  = mk(0,0,1,1,4'd3,  2'd1,1,1,4'd3);
    vt[3]  = mk(0,0,0,1,4'd0,  2'd0,1,0,4'd3);
    vt[4]  = mk(0,0,1,0,4'd4,  2'd1,1,1,4'd4);
    vt[5]  = mk(0,0,1,0,4'd5,  2'd2,0,1,4'd4);
    vt[6]  = mk(0,0,1,0,4'd6,  2'd2,0,1,4'd4);
    vt[7]  = mk(0,0,0,1,4'd0,  2'd1,1,1,4'd5);
    vt[8]  = mk(0,0,0,1,4'd0,  2'd0,1,0,4'd5);
    vt[9]  = mk(0,0,1,0,4'd7,  2'd1,1,1,4'd7);
    vt[10] = mk(0,0,1,0,4'd8,  2'd2,0,1,4'd7);
    vt[11] = mk(1,0,1,0,4'd9,  2'd0,1,0,4'd7);
    vt[12] = mk(0,0,1,0,4'd10, 2'd1,1,1,4'd10);
    vt[13] = mk(1,0,1,0,4'd11, 2'd0,1,0,4'd10);
    vt[14] = mk(0,0,0,1,4'd0,  2'd0,1,0,4'd10);
    vt[15] = mk(0,1,1,1,4'd12, 2'd1,1,0,4'd12);
    vt[16] = mk(0,1,1,1,4'd13, 2'd2,0,0,4'd12);
    vt[17] = mk(0,0,0,1,4'd0,  2'd1,1,1,4'd13);
    vt[18] = mk(0,0,0,1,4'd0,  2'd0,1,0,4'd13);

    rst = 1'b1; rst2 = 1'b1;
    drive(0, 0, 0, 0, 4'd0);
    tick(); tick();
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_ir", in_ready, 1'b1);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_op", out_opcode, 4'd0);
    chk("rst_bub", bubble_cnt, 16'd0);
    chk("rst_bub2", bubble_cnt2, 4'd0);
    rst = 1'b0; rst2 = 1'b0;

    // Idle: both counters climb, the narrow one saturates at 15.
    for (int i = 0; i < 14; i++) tick();
    chk("bub_idle14", bubble_cnt, 16'd14);
    chk("bub2_idle14", bubble_cnt2, 4'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("bub2_idle20", bubble_cnt2, 4'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("bub2_hold", bubble_cnt2, 4'd15);

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].fl, vt[i].st, vt[i].iv, vt[i].ordy, vt[i].op);
      tick();
      chk($sformatf("v%0d_occ", i), occupancy, vt[i].e_occ);
      chk($sformatf("v%0d_ir", i), in_ready, vt[i].e_ir);
      chk($sformatf("v%0d_ov", i), out_valid, vt[i].e_ov);
      chk($sformatf("v%0d_op", i), out_opcode, vt[i].e_op);
      chk($sformatf("v%0d_ad", i), out_ad1, {1'b1, vt[i].e_op});
      chk($sformatf("v%0d_imm", i), out_imm, {vt[i].e_op, vt[i].e_op});
    end

    // Stall holds a single beat for three cycles, then it drains.
    begin
      logic [15:0] b0;
      drive(0, 0, 1, 0, 4'd14);
      tick();
      chk("stall_load_occ", occupancy, 2'd1);
      b0 = bubble_cnt;
      drive(0, 1, 0, 1, 4'd0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk($sformatf("stall%0d_ov", i), out_valid, 1'b0);
        chk($sformatf("stall%0d_occ", i), occupancy, 2'd1);
      end
      chk("stall_bub", bubble_cnt, b0 + 16'd3);
      stall = 1'b0;
      #1;
      chk("stall_drop_ov", out_valid, 1'b1);
      chk("stall_drop_op", out_opcode, 4'd14);
      tick();
      chk("stall_pop_occ", occupancy, 2'd0);
      chk("stall_pop_bub", bubble_cnt, b0 + 16'd3);
    end

    // Reset while full discards both entries and ignores a concurrent beat.
    drive(0, 0, 1, 0, 4'd2);
    tick();
    drive(0, 0, 1, 0, 4'd3);
    tick();
    chk("full_occ", occupancy, 2'd2);
    chk("full_ir", in_ready, 1'b0);
    rst = 1'b1;
    drive(0, 0, 1, 1, 4'd9);
    tick();
    chk("rst2_occ", occupancy, 2'd0);
    chk("rst2_ir", in_ready, 1'b1);
    chk("rst2_ov", out_valid, 1'b0);
    chk("rst2_op", out_opcode, 4'd0);
    chk("rst2_ad", out_ad1, 5'd0);
    chk("rst2_imm", out_imm, 8'd0);
    chk("rst2_bub", bubble_cnt, 16'd0);
    tick();
    chk("rst2_hold_occ", occupancy, 2'd0);
    rst = 1'b0;
    drive(0, 0, 0, 1, 4'd0);
    tick();
    chk("post_rst_occ", occupancy, 2'd0);
    chk("post_rst_bub", bubble_cnt, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
